// File: rtl/mux_word_writer_if.sv
// Purpose: bundles the burst-control, word-input handshake and byte-memory write
//          signals of mux_word_writer so the DUT and its driver share one port.
// Ports  : start/base_addr/word_count (burst control), in_valid/in_ready/in_word
//          (word handshake), mem_wr_en/mem_addr/mem_wr_data (byte write), busy/done.
interface mux_word_writer_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int MEM_WIDTH  = 8,
  parameter int WORD_WIDTH = 16,
  parameter int CNT_WIDTH  = 9
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [CNT_WIDTH-1:0]  word_count;
  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_WIDTH-1:0] in_word;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [MEM_WIDTH-1:0]  mem_wr_data;
  logic                  busy;
  logic                  done;

  // Writer side.
  modport slave (
    input  start, base_addr, word_count, in_valid, in_word,
    output in_ready, mem_wr_en, mem_addr, mem_wr_data, busy, done
  );

  // Producer / controller side.
  modport master (
    output start, base_addr, word_count, in_valid, in_word,
    input  in_ready, mem_wr_en, mem_addr, mem_wr_data, busy, done
  );
endinterface

// File: rtl/mux_word_writer.sv
// Purpose : stores a counted burst of 16-bit mux words into a byte memory, low byte first.
// Latency : word accepted at edge N -> low byte written in cycle N+1, high byte in N+2.
// Backpr. : in_ready only in LOAD, or in WR_HI while words remain; 1 word per 2 cycles max.
// Ports   : clk, nrst (async active-low); bus = mux_word_writer_if.slave carrying
//           start/base_addr/word_count, in_valid/in_ready/in_word, mem_wr_en/mem_addr/
//           mem_wr_data, busy, done. All outputs are decoded from registers only.
module mux_word_writer #(
  parameter int MEM_DEPTH  = 1024,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int MEM_WIDTH  = 8,
  parameter int WORD_WIDTH = 2 * MEM_WIDTH
) (
  input  logic             clk,
  input  logic             nrst,
  mux_word_writer_if.slave bus
);

  localparam int CNT_WIDTH = 9;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WR_LO = 3'd2,
    S_WR_HI = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [CNT_WIDTH-1:0]  r_rem;
  logic [WORD_WIDTH-1:0] r_word;
  logic                  w_in_ready;
  logic                  w_xfer;

  // Ready depends only on state and the remaining count, never on in_valid.
  // During WR_HI the next word may be taken while the current high byte is
  // still being written, since r_word only updates at the closing edge.
  assign w_in_ready   = (r_state == S_LOAD) ||
                        ((r_state == S_WR_HI) && (r_rem != '0));
  assign w_xfer       = bus.in_valid && w_in_ready;
  assign bus.in_ready = w_in_ready;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ptr  <= '0;
      r_rem  <= '0;
      r_word <= '0;
    end else begin
      if ((r_state == S_IDLE) && bus.start) begin
        r_ptr <= bus.base_addr;
        r_rem <= bus.word_count;
      end
      // Pointer wraps naturally at MEM_DEPTH through the fixed width.
      if (r_state == S_WR_HI) begin
        r_ptr <= r_ptr + ADDR_WIDTH'(2);
      end
      if (w_xfer) begin
        r_word <= bus.in_word;
        r_rem  <= r_rem - CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    bus.mem_wr_en   = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wr_data = '0;
    bus.busy        = 1'b1;
    bus.done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          w_next = (bus.word_count == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_xfer) begin
          w_next = S_WR_LO;
        end
      end
      S_WR_LO: begin
        bus.mem_wr_en   = 1'b1;
        bus.mem_addr    = r_ptr;
        bus.mem_wr_data = r_word[MEM_WIDTH-1:0];
        w_next          = S_WR_HI;
      end
      S_WR_HI: begin
        bus.mem_wr_en   = 1'b1;
        bus.mem_addr    = r_ptr + ADDR_WIDTH'(1);
        bus.mem_wr_data = r_word[WORD_WIDTH-1 -: MEM_WIDTH];
        if (w_xfer) begin
          w_next = S_WR_LO;
        end else if (r_rem == '0) begin
          w_next = S_DONE;
        end else begin
          w_next = S_LOAD;
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        w_next   = S_IDLE;
      end
      default: begin
        bus.busy = 1'b0;
        w_next   = S_IDLE;
      end
    endcase
  end

endmodule
